// File: rtl/pc_seq_unit.sv
// pc_seq_unit: fetch-path program counter with jump, call/return stack,
// halt and saturate-or-wrap at the top of the address space.
module pc_seq_unit #(
  parameter int         ADDR_W       = 5,
  parameter int         STACK_DEPTH  = 4,
  parameter logic [1:0] UPDATE_PHASE = 2'b11,
  parameter bit         WRAP_EN      = 1'b0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [1:0]                         Timing_Signal,
  input  logic                               halt,
  input  logic                               jump_en,
  input  logic [ADDR_W-1:0]                  jump_addr,
  input  logic                               call_en,
  input  logic                               ret_en,
  output logic [ADDR_W-1:0]                  PC_out,
  output logic                               at_end,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_depth,
  output logic                               stack_overflow,
  output logic                               stack_underflow
);

  localparam int            SW   = $clog2(STACK_DEPTH + 1);
  localparam logic [SW-1:0] FULL = SW'(STACK_DEPTH);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_stack [STACK_DEPTH];
  logic [SW-1:0]     r_depth;
  logic              r_ovf;
  logic              r_unf;

  logic              w_upd;
  logic              w_full;
  logic              w_empty;
  logic              w_at_end;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [SW-1:0]     w_top_idx;
  logic [ADDR_W-1:0] w_top;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [SW-1:0]     w_depth_nxt;
  logic              w_push;
  logic              w_set_ovf;
  logic              w_set_unf;

  assign w_upd     = (Timing_Signal == UPDATE_PHASE) && !halt && !reset;
  assign w_full    = (r_depth == FULL);
  assign w_empty   = (r_depth == '0);
  assign w_at_end  = &r_pc;
  // Return address wraps to 0 at the top regardless of WRAP_EN.
  assign w_pc_inc  = r_pc + ADDR_W'(1);
  assign w_top_idx = r_depth - SW'(1);
  assign w_top     = r_stack[w_top_idx];

  // Next-state selection: ret > call > jump > increment.
  always_comb begin
    w_pc_nxt    = r_pc;
    w_depth_nxt = r_depth;
    w_push      = 1'b0;
    w_set_ovf   = 1'b0;
    w_set_unf   = 1'b0;
    if (w_upd) begin
      if (ret_en) begin
        if (w_empty) begin
          w_set_unf = 1'b1;
        end else begin
          w_pc_nxt    = w_top;
          w_depth_nxt = r_depth - SW'(1);
        end
      end else if (call_en) begin
        if (w_full) begin
          w_set_ovf = 1'b1;
        end else begin
          w_push      = 1'b1;
          w_pc_nxt    = jump_addr;
          w_depth_nxt = r_depth + SW'(1);
        end
      end else if (jump_en) begin
        w_pc_nxt = jump_addr;
      end else if (!w_at_end) begin
        w_pc_nxt = w_pc_inc;
      end else if (WRAP_EN) begin
        w_pc_nxt = '0;
      end
    end
  end

  // PC, depth and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= '0;
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_pc    <= w_pc_nxt;
      r_depth <= w_depth_nxt;
      if (w_set_ovf) r_ovf <= 1'b1;
      if (w_set_unf) r_unf <= 1'b1;
    end
  end

  // Return stack storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_stack[r_depth] <= w_pc_inc;
  end

  assign PC_out          = r_pc;
  assign at_end          = w_at_end;
  assign stack_depth     = r_depth;
  assign stack_overflow  = r_ovf;
  assign stack_underflow = r_unf;

endmodule

// File: tb/tb_pc_seq_unit.sv
// tb_pc_seq_unit: directed stimulus with a queued scoreboard.
// A saturating and a wrapping instance share all inputs.
module tb_pc_seq_unit;

  typedef struct {
    logic [4:0] pc;
    logic [2:0] dep;
    logic       ovf;
    logic       unf;
    bit         wchk;
    logic [4:0] wpc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] Timing_Signal = 2'b00;
  logic       halt = 1'b0;
  logic       jump_en = 1'b0;
  logic [4:0] jump_addr = '0;
  logic       call_en = 1'b0;
  logic       ret_en = 1'b0;

  logic [4:0] pc_s, pc_w;
  logic       end_s, end_w;
  logic [2:0] dep_s, dep_w;
  logic       ovf_s, ovf_w, unf_s, unf_w;

  logic       s_reset = 1'b1;
  logic       s_halt = 1'b0;
  logic       s_jump = 1'b0;
  logic       s_call = 1'b0;
  logic       s_ret = 1'b0;
  logic [4:0] s_ja = '0;

  exp_t q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pc_seq_unit u_sat (
    .clk(clk), .reset(reset), .Timing_Signal(Timing_Signal),
    .halt(halt), .jump_en(jump_en), .jump_addr(jump_addr),
    .call_en(call_en), .ret_en(ret_en), .PC_out(pc_s),
    .at_end(end_s), .stack_depth(dep_s),
    .stack_overflow(ovf_s), .stack_underflow(unf_s)
  );

  pc_seq_unit #(.WRAP_EN(1'b1)) u_wrap (
    .clk(clk), .reset(reset), .Timing_Signal(Timing_Signal),
    .halt(halt), .jump_en(jump_en), .jump_addr(jump_addr),
    .call_en(call_en), .ret_en(ret_en), .PC_out(pc_w),
    .at_end(end_w), .stack_depth(dep_w),
    .stack_overflow(ovf_w), .stack_underflow(unf_w)
  );

  function automatic exp_t mk(input int pc, input int dep,
                              input int ovf, input int unf);
    exp_t e;
    e.pc   = 5'(pc);
    e.dep  = 3'(dep);
    e.ovf  = 1'(ovf);
    e.unf  = 1'(unf);
    e.wchk = 1'b0;
    e.wpc  = '0;
    return e;
  endfunction

  function automatic exp_t mkw(input int pc, input int wpc);
    exp_t e;
    e      = mk(pc, 0, 0, 0);
    e.wchk = 1'b1;
    e.wpc  = 5'(wpc);
    return e;
  endfunction

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0d expected %0d", n, $time, act, exp);
    end
  endtask

  // Monitor: one expectation per clock, compared just after the edge.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pc", int'(pc_s), int'(e.pc));
      chk("at_end", int'(end_s), int'(e.pc == 5'd31));
      chk("depth", int'(dep_s), int'(e.dep));
      chk("overflow", int'(ovf_s), int'(e.ovf));
      chk("underflow", int'(unf_s), int'(e.unf));
      if (e.wchk) begin
        chk("wrap_pc", int'(pc_w), int'(e.wpc));
        chk("wrap_at_end", int'(end_w), int'(e.wpc == 5'd31));
      end
    end
  end

  task automatic cyc(input logic [1:0] ph, input bit c, input exp_t e);
    @(negedge clk);
    Timing_Signal = ph;
    reset         = s_reset;
    halt          = s_halt;
    jump_en       = s_jump;
    call_en       = s_call;
    ret_en        = s_ret;
    jump_addr     = s_ja;
    if (c) begin
      q.push_back(e);
      cur = e;
    end
  endtask

  // One machine cycle: state holds on T0..T2, updates on T3.
  task automatic step(input exp_t e);
    exp_t h;
    h = cur;
    for (int p = 0; p < 3; p++) cyc(2'(p), 1'b1, h);
    cyc(2'b11, 1'b1, e);
  endtask

  task automatic strb(input logic r, input logic c,
                      input logic j, input int a);
    s_ret  = r;
    s_call = c;
    s_jump = j;
    s_ja   = 5'(a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    cur = mk(0, 0, 0, 0);
    // reset on a T3 edge, then legacy counting
    s_reset = 1'b1;
    cyc(2'b11, 1'b1, mkw(0, 0));
    cyc(2'b00, 1'b1, mkw(0, 0));
    s_reset = 1'b0;
    for (int k = 1; k <= 5; k++) step(mkw(k, k));
    s_halt = 1'b1;
    step(mkw(5, 5));
    s_halt = 1'b0;
    for (int k = 6; k <= 31; k++) step(mkw(k, k));
    step(mkw(31, 0));
    step(mkw(31, 1));

    // call/return basic
    s_reset = 1'b1;
    cyc(2'b00, 1'b1, mk(0, 0, 0, 0));
    s_reset = 1'b0;
    strb(0, 0, 1, 7);  step(mk(7, 0, 0, 0));
    strb(0, 1, 0, 20); step(mk(20, 1, 0, 0));
    strb(0, 0, 0, 0);  step(mk(21, 1, 0, 0));
    step(mk(22, 1, 0, 0));
    strb(1, 0, 0, 0);  step(mk(8, 0, 0, 0));

    // nested calls to overflow, unwind to underflow
    strb(0, 1, 0, 10); step(mk(10, 1, 0, 0));
    strb(0, 1, 0, 15); step(mk(15, 2, 0, 0));
    strb(0, 1, 0, 3);  step(mk(3, 3, 0, 0));
    strb(0, 1, 0, 31); step(mk(31, 4, 0, 0));
    strb(0, 1, 0, 0);  step(mk(31, 4, 1, 0));
    strb(1, 0, 0, 0);  step(mk(4, 3, 1, 0));
    step(mk(16, 2, 1, 0));
    step(mk(11, 1, 1, 0));
    step(mk(9, 0, 1, 0));
    step(mk(9, 0, 1, 1));

    // return address from the top of memory is 0
    strb(0, 0, 1, 31); step(mk(31, 0, 1, 1));
    strb(0, 1, 0, 2);  step(mk(2, 1, 1, 1));
    strb(1, 0, 0, 0);  step(mk(0, 0, 1, 1));

    // simultaneous strobes
    s_reset = 1'b1;
    strb(0, 0, 0, 0);
    cyc(2'b00, 1'b1, mk(0, 0, 0, 0));
    s_reset = 1'b0;
    strb(0, 0, 1, 5);  step(mk(5, 0, 0, 0));
    strb(0, 1, 0, 12); step(mk(12, 1, 0, 0));
    strb(1, 1, 1, 25); step(mk(6, 0, 0, 0));
    strb(0, 1, 1, 18); step(mk(18, 1, 0, 0));
    strb(1, 0, 0, 0);  step(mk(7, 0, 0, 0));

    // build PC=13, depth=2, overflow=1, then reset off-phase
    strb(0, 1, 0, 1);  step(mk(1, 1, 0, 0));
    strb(0, 1, 0, 2);  step(mk(2, 2, 0, 0));
    strb(0, 1, 0, 3);  step(mk(3, 3, 0, 0));
    strb(0, 1, 0, 4);  step(mk(4, 4, 0, 0));
    strb(0, 1, 0, 9);  step(mk(4, 4, 1, 0));
    strb(1, 0, 0, 0);  step(mk(4, 3, 1, 0));
    step(mk(3, 2, 1, 0));
    strb(0, 0, 1, 13); step(mk(13, 2, 1, 0));
    s_reset = 1'b1;
    cyc(2'b01, 1'b1, mk(0, 0, 0, 0));
    s_reset = 1'b0;
    strb(1, 0, 0, 0);  step(mk(0, 0, 0, 1));
    strb(0, 0, 0, 0);  step(mk(1, 0, 0, 1));

    cyc(2'b00, 1'b0, cur);
    cyc(2'b00, 1'b0, cur);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
